// File: rtl/mac_iter_scheduler.sv
// Iteration scheduler: runs nb_iter streamer/engine scalar-product passes over strided A/B/C/D addresses.
// Defining MAC_ITER_SCHED_DBG_STEP_EN adds a single-step hold in UPDATEIDX (dbg_active_i/dbg_step_i).
module mac_iter_scheduler #(
    parameter int  CNT_LEN   = 1024,
    parameter int  NB_ITER_W = 16,
    localparam int LW        = $clog2(CNT_LEN) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 start_i,
`ifdef MAC_ITER_SCHED_DBG_STEP_EN
    input  logic                 dbg_active_i,
    input  logic                 dbg_step_i,
`endif
    input  logic [31:0]          base_a_i,
    input  logic [31:0]          base_b_i,
    input  logic [31:0]          base_c_i,
    input  logic [31:0]          base_d_i,
    input  logic [31:0]          iter_stride_i,
    input  logic [NB_ITER_W-1:0] nb_iter_i,
    input  logic [LW-1:0]        len_i,
    input  logic                 strm_ready_i,
    output logic                 strm_req_o,
    output logic [31:0]          a_addr_o,
    output logic [31:0]          b_addr_o,
    output logic [31:0]          c_addr_o,
    output logic [31:0]          d_addr_o,
    output logic [LW-1:0]        len_o,
    output logic                 eng_start_o,
    output logic                 eng_clear_o,
    input  logic                 eng_acc_done_i,
    input  logic                 strm_done_i,
    output logic [NB_ITER_W-1:0] iter_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_COMPUTE   = 3'd2,
        S_WAIT      = 3'd3,
        S_UPDATEIDX = 3'd4,
        S_TERMINATE = 3'd5
    } state_t;

    state_t               state, next_state;
    logic [NB_ITER_W-1:0] nb_iter_q, iter_q;
    logic [31:0]          stride_q;
    logic [LW-1:0]        len_q;
    logic                 wb_seen, clr_pending;
    logic                 step_ok, last_iter, degenerate;

`ifdef MAC_ITER_SCHED_DBG_STEP_EN
    assign step_ok = !dbg_active_i || dbg_step_i;
`else
    assign step_ok = 1'b1;
`endif

    assign last_iter  = (iter_q + NB_ITER_W'(1)) == nb_iter_q;
    assign degenerate = (nb_iter_i == '0) || (len_i == '0);

    assign busy_o  = state != S_IDLE;
    assign state_o = state;
    assign iter_o  = iter_q;
    assign len_o   = len_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        strm_req_o  = 1'b0;
        eng_start_o = 1'b0;
        eng_clear_o = 1'b0;
        done_o      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) next_state = degenerate ? S_TERMINATE : S_START;
            end
            S_START: begin
                strm_req_o  = strm_ready_i;
                eng_start_o = strm_ready_i;
                eng_clear_o = clr_pending;
                if (strm_ready_i) next_state = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (eng_acc_done_i) next_state = (strm_done_i || wb_seen) ? S_UPDATEIDX : S_WAIT;
            end
            S_WAIT: begin
                if (strm_done_i) next_state = S_UPDATEIDX;
            end
            S_UPDATEIDX: begin
                if (step_ok) next_state = last_iter ? S_TERMINATE : S_START;
            end
            S_TERMINATE: begin
                done_o     = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (clear_i) next_state = S_IDLE;
    end

    // Job registers; clr_pending marks the first START cycle of each iteration.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_addr_o    <= '0;
            b_addr_o    <= '0;
            c_addr_o    <= '0;
            d_addr_o    <= '0;
            stride_q    <= '0;
            nb_iter_q   <= '0;
            len_q       <= '0;
            iter_q      <= '0;
            wb_seen     <= 1'b0;
            clr_pending <= 1'b0;
        end else if (clear_i) begin
            a_addr_o    <= '0;
            b_addr_o    <= '0;
            c_addr_o    <= '0;
            d_addr_o    <= '0;
            stride_q    <= '0;
            nb_iter_q   <= '0;
            len_q       <= '0;
            iter_q      <= '0;
            wb_seen     <= 1'b0;
            clr_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        a_addr_o    <= base_a_i;
                        b_addr_o    <= base_b_i;
                        c_addr_o    <= base_c_i;
                        d_addr_o    <= base_d_i;
                        stride_q    <= iter_stride_i;
                        nb_iter_q   <= nb_iter_i;
                        len_q       <= len_i;
                        iter_q      <= '0;
                        wb_seen     <= 1'b0;
                        clr_pending <= 1'b1;
                    end
                end
                S_START: clr_pending <= 1'b0;
                S_COMPUTE: begin
                    if (strm_done_i) wb_seen <= 1'b1;
                end
                S_UPDATEIDX: begin
                    wb_seen <= 1'b0;
                    if (step_ok && !last_iter) begin
                        iter_q      <= iter_q + NB_ITER_W'(1);
                        a_addr_o    <= a_addr_o + stride_q;
                        b_addr_o    <= b_addr_o + stride_q;
                        c_addr_o    <= c_addr_o + stride_q;
                        d_addr_o    <= d_addr_o + stride_q;
                        clr_pending <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_iter_scheduler.sv
// Scoreboard bench for mac_iter_scheduler: directed jobs push expected request/done events,
// a negedge monitor pops and compares them whenever the DUT raises strm_req_o or done_o.
module tb_mac_iter_scheduler;

    localparam int LW = 11;
    localparam int NW = 16;
    localparam logic [31:0] ST_IDLE = 0, ST_START = 1, ST_COMPUTE = 2,
                            ST_WAIT = 3, ST_UPD = 4, ST_TERM = 5;

    logic          clk_i = 1'b0, rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0;
    logic [31:0]   base_a_i = '0, base_b_i = '0, base_c_i = '0, base_d_i = '0, iter_stride_i = '0;
    logic [NW-1:0] nb_iter_i = '0;
    logic [LW-1:0] len_i = '0;
    logic          strm_ready_i = 1'b0, eng_acc_done_i = 1'b0, strm_done_i = 1'b0;
    logic          strm_req_o, eng_start_o, eng_clear_o, busy_o, done_o;
    logic [31:0]   a_addr_o, b_addr_o, c_addr_o, d_addr_o;
    logic [LW-1:0] len_o;
    logic [NW-1:0] iter_o;
    logic [2:0]    state_o;
`ifdef MAC_ITER_SCHED_DBG_STEP_EN
    logic          dbg_active_i = 1'b0, dbg_step_i = 1'b0;
`endif

    typedef struct {
        bit          is_done;
        logic [31:0] iter, a, b, c, d, len;
        logic        clr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0, clr_count = 0;
    logic [31:0] cur_len = '0;

    always #5 clk_i = ~clk_i;

    mac_iter_scheduler #(.CNT_LEN(1024), .NB_ITER_W(NW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
`ifdef MAC_ITER_SCHED_DBG_STEP_EN
        .dbg_active_i(dbg_active_i), .dbg_step_i(dbg_step_i),
`endif
        .base_a_i(base_a_i), .base_b_i(base_b_i), .base_c_i(base_c_i), .base_d_i(base_d_i),
        .iter_stride_i(iter_stride_i), .nb_iter_i(nb_iter_i), .len_i(len_i),
        .strm_ready_i(strm_ready_i), .strm_req_o(strm_req_o),
        .a_addr_o(a_addr_o), .b_addr_o(b_addr_o), .c_addr_o(c_addr_o), .d_addr_o(d_addr_o),
        .len_o(len_o), .eng_start_o(eng_start_o), .eng_clear_o(eng_clear_o),
        .eng_acc_done_i(eng_acc_done_i), .strm_done_i(strm_done_i),
        .iter_o(iter_o), .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input int it, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic [31:0] d, input logic clr);
        exp_t e;
        e.is_done = 1'b0; e.iter = 32'(it); e.a = a; e.b = b; e.c = c; e.d = d;
        e.len = cur_len; e.clr = clr;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int it);
        exp_t e;
        e.is_done = 1'b1; e.iter = 32'(it); e.a = '0; e.b = '0; e.c = '0; e.d = '0;
        e.len = cur_len; e.clr = 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: every request or done seen on the DUT must match the oldest expected event.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_i) begin
            if (eng_clear_o) clr_count++;
            if (strm_req_o || done_o) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_event", 32'({strm_req_o, done_o}), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_event_kind", 32'(done_o), 32'(e.is_done));
                    check("sb_iter", 32'(iter_o), e.iter);
                    if (!e.is_done) begin
                        check("sb_a_addr", a_addr_o, e.a);
                        check("sb_b_addr", b_addr_o, e.b);
                        check("sb_c_addr", c_addr_o, e.c);
                        check("sb_d_addr", d_addr_o, e.d);
                        check("sb_len", 32'(len_o), e.len);
                        check("sb_eng_start", 32'(eng_start_o), 32'(1));
                        check("sb_eng_clear", 32'(eng_clear_o), 32'(e.clr));
                    end else begin
                        check("sb_done_no_req", 32'(strm_req_o), 32'(0));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_state(input logic [31:0] s, input int budget);
        int n = 0;
        while (32'(state_o) !== s && n < budget) begin
            tick();
            n++;
        end
        check("wait_state_reached", 32'(state_o), s);
    endtask

    task automatic setup(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] d, input logic [31:0] stride,
                         input logic [NW-1:0] nb, input logic [LW-1:0] len);
        base_a_i = a; base_b_i = b; base_c_i = c; base_d_i = d;
        iter_stride_i = stride; nb_iter_i = nb; len_i = len;
        cur_len = 32'(len);
    endtask

    task automatic launch();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Pulse strm_done at cycle sd and acc_done at cycle ad (0 = first COMPUTE cycle).
    task automatic complete(input int sd, input int ad, output int waits);
        int span = (sd > ad) ? sd : ad;
        waits = 0;
        for (int c = 0; c <= span; c++) begin
            strm_done_i    = (c == sd);
            eng_acc_done_i = (c == ad);
            tick();
            if (32'(state_o) == ST_WAIT) waits++;
        end
        strm_done_i    = 1'b0;
        eng_acc_done_i = 1'b0;
    endtask

    task automatic run_iter(input int sd, input int ad, input bit is_last);
        int w;
        wait_state(ST_COMPUTE, 20);
        complete(sd, ad, w);
        check("updateidx_after_done", 32'(state_o), ST_UPD);
        tick();
        if (is_last) begin
            check("terminate_state", 32'(state_o), ST_TERM);
            check("done_pulse", 32'(done_o), 32'(1));
            tick();
            check("idle_after_terminate", 32'(state_o), ST_IDLE);
            check("done_one_cycle", 32'(done_o), 32'(0));
        end else begin
            check("next_iter_start", 32'(state_o), ST_START);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_state"}, 32'(state_o), ST_IDLE);
        check({tag, "_ctrl"}, 32'({busy_o, done_o, strm_req_o, eng_start_o, eng_clear_o}), 32'(0));
        check({tag, "_a_addr"}, a_addr_o, 32'h0);
        check({tag, "_d_addr"}, d_addr_o, 32'h0);
        check({tag, "_len"}, 32'(len_o), 32'(0));
        check({tag, "_iter"}, 32'(iter_o), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        int c0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check_cleared("reset");
        check("reset_b_addr", b_addr_o, 32'h0);
        check("reset_c_addr", c_addr_o, 32'h0);

        // Basic run: three iterations, ready tied high, both dones in the same cycle.
        strm_ready_i = 1'b1;
        setup(32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h40, 16'd3, 11'd16);
        push_req(0, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 1'b1);
        push_req(1, 32'h1040, 32'h2040, 32'h3040, 32'h4040, 1'b1);
        push_req(2, 32'h1080, 32'h2080, 32'h3080, 32'h4080, 1'b1);
        push_done(2);
        launch();
        check("basic_start_cycle1", 32'(state_o), ST_START);
        check("basic_req_start_clear_cycle1", 32'({strm_req_o, eng_start_o, eng_clear_o}), 32'h7);
        check("basic_busy", 32'(busy_o), 32'(1));
        for (int i = 0; i < 3; i++) run_iter(0, 0, i == 2);
        check("basic_sb_drained", 32'(exp_q.size()), 32'(0));

        // Ordering: write-back first (no WAIT), then accumulation first with a 5-cycle gap.
        setup(32'h8000, 32'h9000, 32'hA000, 32'hB000, 32'h20, 16'd2, 11'd8);
        push_req(0, 32'h8000, 32'h9000, 32'hA000, 32'hB000, 1'b1);
        push_req(1, 32'h8020, 32'h9020, 32'hA020, 32'hB020, 1'b1);
        push_done(1);
        launch();
        wait_state(ST_COMPUTE, 5);
        complete(0, 2, w);
        check("order_wb_first_no_wait", 32'(w), 32'(0));
        check("order_upd_one_after_acc", 32'(state_o), ST_UPD);
        tick();
        check("order_second_start", 32'(state_o), ST_START);
        wait_state(ST_COMPUTE, 5);
        complete(5, 0, w);
        check("order_acc_first_wait5", 32'(w), 32'(5));
        check("order_upd_after_wb", 32'(state_o), ST_UPD);
        tick();
        check("order_terminate", 32'(state_o), ST_TERM);
        tick();
        check("order_sb_drained", 32'(exp_q.size()), 32'(0));

        // Degenerate jobs: straight to TERMINATE, no streamer request.
        setup(32'h1, 32'h2, 32'h3, 32'h4, 32'h4, 16'd0, 11'd8);
        push_done(0);
        launch();
        check("degen_nb0_terminate", 32'(state_o), ST_TERM);
        tick();
        check("degen_nb0_idle", 32'(state_o), ST_IDLE);
        setup(32'h1, 32'h2, 32'h3, 32'h4, 32'h4, 16'd4, 11'd0);
        push_done(0);
        launch();
        check("degen_len0_terminate", 32'(state_o), ST_TERM);
        tick();
        check("degen_len0_idle", 32'(state_o), ST_IDLE);
        check("degen_sb_drained", 32'(exp_q.size()), 32'(0));

        // Backpressure for 10 START cycles, with a start pulse issued while busy.
        strm_ready_i = 1'b0;
        setup(32'h100, 32'h200, 32'h300, 32'h400, 32'h10, 16'd1, 11'd4);
        push_req(0, 32'h100, 32'h200, 32'h300, 32'h400, 1'b0);
        push_done(0);
        c0 = clr_count;
        launch();
        check("bp_start_state", 32'(state_o), ST_START);
        check("bp_no_req_while_not_ready", 32'({strm_req_o, eng_start_o}), 32'(0));
        check("bp_clear_first_cycle", 32'(eng_clear_o), 32'(1));
        for (int k = 1; k < 10; k++) begin
            if (k == 4) begin
                base_a_i  = 32'hDEAD0000;
                nb_iter_i = 16'd7;
                start_i   = 1'b1;
            end
            tick();
            start_i = 1'b0;
        end
        check("bp_held_in_start", 32'(state_o), ST_START);
        check("bp_busy_start_ignored", a_addr_o, 32'h100);
        strm_ready_i = 1'b1;
        tick();
        check("bp_compute_after_ready", 32'(state_o), ST_COMPUTE);
        check("bp_clear_exactly_once", 32'(clr_count - c0), 32'(1));
        run_iter(0, 0, 1'b1);
        check("bp_sb_drained", 32'(exp_q.size()), 32'(0));

        // Address wrap-around modulo 2^32.
        setup(32'hFFFFFFC0, 32'h5000, 32'h6000, 32'hFFFFFF80, 32'h40, 16'd2, 11'd32);
        push_req(0, 32'hFFFFFFC0, 32'h5000, 32'h6000, 32'hFFFFFF80, 1'b1);
        push_req(1, 32'h00000000, 32'h5040, 32'h6040, 32'hFFFFFFC0, 1'b1);
        push_done(1);
        launch();
        run_iter(0, 0, 1'b0);
        run_iter(0, 0, 1'b1);
        check("wrap_sb_drained", 32'(exp_q.size()), 32'(0));

        // Abort with clear_i in COMPUTE of iteration 1.
        setup(32'h10, 32'h20, 32'h30, 32'h40, 32'h100, 16'd3, 11'd5);
        push_req(0, 32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        push_req(1, 32'h110, 32'h120, 32'h130, 32'h140, 1'b1);
        launch();
        run_iter(0, 0, 1'b0);
        wait_state(ST_COMPUTE, 5);
        check("clr_abort_iter1", 32'(iter_o), 32'(1));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_cleared("clr_abort");
        repeat (4) tick();
        check("clr_abort_stays_idle", 32'(state_o), ST_IDLE);
        check("clr_abort_sb_drained", 32'(exp_q.size()), 32'(0));

        // Abort with asynchronous rst_i mid-cycle in COMPUTE of iteration 1.
        push_req(0, 32'h10, 32'h20, 32'h30, 32'h40, 1'b1);
        push_req(1, 32'h110, 32'h120, 32'h130, 32'h140, 1'b1);
        launch();
        run_iter(0, 0, 1'b0);
        wait_state(ST_COMPUTE, 5);
        #2 rst_i = 1'b1;
        #1;
        check_cleared("rst_abort");
        tick();
        rst_i = 1'b0;
        repeat (4) tick();
        check("rst_abort_stays_idle", 32'(state_o), ST_IDLE);
        check("rst_abort_sb_drained", 32'(exp_q.size()), 32'(0));

`ifdef MAC_ITER_SCHED_DBG_STEP_EN
        // Debug single-step: UPDATEIDX holds until dbg_step_i.
        dbg_active_i = 1'b1;
        setup(32'h200, 32'h300, 32'h400, 32'h500, 32'h8, 16'd2, 11'd4);
        push_req(0, 32'h200, 32'h300, 32'h400, 32'h500, 1'b1);
        push_req(1, 32'h208, 32'h308, 32'h408, 32'h508, 1'b1);
        push_done(1);
        launch();
        wait_state(ST_COMPUTE, 5);
        complete(0, 0, w);
        for (int k = 0; k < 3; k++) begin
            check("dbg_hold_updateidx", 32'(state_o), ST_UPD);
            tick();
        end
        check("dbg_hold_addr", a_addr_o, 32'h200);
        dbg_step_i = 1'b1;
        tick();
        dbg_step_i = 1'b0;
        check("dbg_step_to_start", 32'(state_o), ST_START);
        wait_state(ST_COMPUTE, 5);
        complete(0, 0, w);
        tick();
        check("dbg_hold_last", 32'(state_o), ST_UPD);
        dbg_step_i = 1'b1;
        tick();
        dbg_step_i = 1'b0;
        check("dbg_step_to_terminate", 32'(state_o), ST_TERM);
        tick();
        dbg_active_i = 1'b0;
        check("dbg_sb_drained", 32'(exp_q.size()), 32'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
